fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 11 +
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between fetch_unit (master) and the memory (slave).
// One request at a time: imem_req pulses with imem_addr, imem_valid returns imem_rdata later.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem reads feeding the IF/ID register.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned branch targets on a sticky fault output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         br_taken,
    input  logic [31:0]  br_target,
    fetch_unit_if.master imem,
    output logic [31:0]  PCmas4_Out,
    output logic [3:0]   opcode,
    output logic [3:0]   Rg,
    output logic [3:0]   Rp,
    output logic [3:0]   Rs,
    output logic [23:0]  imm24,
    output logic [15:0]  imm16,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic         fault,
`endif
    output logic         valid_out
);

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_hold, w_hold_nxt;
    logic        r_discard, w_discard_nxt;
    logic [31:0] r_instr, r_pc4;
    logic        r_valid;
    logic        w_complete;
    logic [31:0] w_load_instr;
    logic [31:0] w_br_pc;
    logic        w_fault_set;
    logic        w_halt;
    logic        w_kill;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    assign w_br_pc     = br_target;
    assign w_fault_set = br_taken && (br_target[1:0] != 2'b00);
    assign w_halt      = r_fault;
    assign fault       = r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fault <= 1'b0;
        else        r_fault <= r_fault | w_fault_set;
    end
`else
    assign w_br_pc     = br_target & ~32'h3;
    assign w_fault_set = 1'b0;
    assign w_halt      = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_hold_nxt    = r_hold;
        w_discard_nxt = r_discard;
        w_complete    = 1'b0;
        w_load_instr  = imem.imem_rdata;
        case (r_state)
            S_BOOT: w_state_nxt = S_REQ;
            S_REQ: begin
                // The request already left this cycle, so its beat must be dropped.
                w_state_nxt = S_WAIT;
                if (br_taken) w_discard_nxt = 1'b1;
            end
            S_WAIT: begin
                if (imem.imem_valid) begin
                    if (r_discard || br_taken) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else if (stall) begin
                        w_hold_nxt  = imem.imem_rdata;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end else if (br_taken) begin
                    w_discard_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (br_taken) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_complete   = 1'b1;
                    w_load_instr = r_hold;
                    w_state_nxt  = S_REQ;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
        // A fault parks the FSM in BOOT with requests gated off until reset.
        if (w_fault_set || w_halt) begin
            w_state_nxt = S_BOOT;
            w_complete  = 1'b0;
        end
        if (w_complete) w_pc_nxt = r_pc + 32'd4;
        if (br_taken)   w_pc_nxt = w_br_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_hold    <= '0;
            r_discard <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_hold    <= w_hold_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    assign w_kill = flush || w_fault_set || w_halt;

    // valid_out is a one-cycle strobe per delivered instruction, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc4   <= '0;
        end else begin
            if (w_kill)      r_valid <= 1'b0;
            else if (!stall) r_valid <= w_complete;
            if (w_complete && !w_kill) begin
                r_instr <= w_load_instr;
                r_pc4   <= r_pc + 32'd4;
            end
        end
    end

    assign imem.imem_req  = (r_state == S_REQ) && !w_halt;
    assign imem.imem_addr = r_pc;

    assign valid_out  = r_valid;
    assign PCmas4_Out = r_pc4;
    assign opcode     = r_instr[31:28];
    assign Rg         = r_instr[27:24];
    assign Rp         = r_instr[23:20];
    assign Rs         = r_instr[19:16];
    assign imm24      = r_instr[23:0];
    assign imm16      = r_instr[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by a randomized run against an address-level memory and
// program-flow scoreboard for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, br_taken;
    logic [31:0] br_target;
    logic [31:0] PCmas4_Out;
    logic [3:0]  opcode, Rg, Rp, Rs;
    logic [23:0] imm24;
    logic [15:0] imm16;
    logic        valid_out;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fault;
`endif

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem       (bus),
        .PCmas4_Out (PCmas4_Out),
        .opcode     (opcode),
        .Rg         (Rg),
        .Rp         (Rp),
        .Rs         (Rs),
        .imm24      (imm24),
        .imm16      (imm16),
`ifdef FETCH_ALIGN_CHECK_EN
        .fault      (fault),
`endif
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [95:0] snap();
        return {31'd0, valid_out, PCmas4_Out, opcode, Rg, Rp, Rs, imm16};
    endfunction

    function automatic logic [95:0] fields();
        return {64'd0, opcode, Rg, Rp, Rs, imm16};
    endfunction

    logic [31:0] exp_next, out_addr, br_tgt, tgt, e_addr;
    bit          br_flag, pend;
    int          cd, n_req, n_del;

    initial begin
        rst_n = 1'b0; stall = 0; flush = 0; br_taken = 0; br_target = '0;
        bus.imem_valid = 1'b0; bus.imem_rdata = '0;
        tick(); tick();
        check("rst_req",   bus.imem_req, 0);
        check("rst_addr",  bus.imem_addr, 0);
        check("rst_valid", valid_out, 0);
        check("rst_fields", {PCmas4_Out, imm24, opcode, Rg, imm16}, 0);

        // Reset release, 1-cycle memory returning 0x1E3F_00AB
        rst_n = 1'b1;
        check("boot_req", bus.imem_req, 0);
        tick();
        check("req_cycle2", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0});
        tick();
        check("wait_noreq", bus.imem_req, 0);
        bus.imem_valid = 1; bus.imem_rdata = 32'h1E3F_00AB;
        tick();
        bus.imem_valid = 0;
        check("first_valid", valid_out, 1);
        check("first_fields", fields(), {64'd0, 4'h1, 4'hE, 4'h3, 4'hF, 16'h00AB});
        check("first_imm24", imm24, 24'h3F_00AB);
        check("first_pc4", PCmas4_Out, 32'h4);
        check("next_req", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h4});

        // Data returned under a 3-cycle stall
        tick();
        check("strobe_clear", valid_out, 0);
        stall = 1; bus.imem_valid = 1; bus.imem_rdata = 32'hA123_4567;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.imem_valid = 0;
            check("stall_hold", {fields(), valid_out, bus.imem_req},
                  {64'd0, 4'h1, 4'hE, 4'h3, 4'hF, 16'h00AB, 1'b0, 1'b0});
        end
        stall = 0;
        tick();
        check("hold_release", {valid_out, fields()}, {1'b1, 64'd0, 32'hA123_4567});
        check("hold_pc4", PCmas4_Out, 32'h8);
        check("hold_next_req", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h8});

        // Branch in WAIT drops the returning beat, even under stall
        tick();
        br_taken = 1; br_target = 32'h100;
        tick();
        br_taken = 0;
        stall = 1; bus.imem_valid = 1; bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        stall = 0; bus.imem_valid = 0;
        check("br_drop_valid", valid_out, 0);
        check("br_redirect", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h100});

        tick();
        bus.imem_valid = 1; bus.imem_rdata = 32'h2000_0000;
        tick();
        bus.imem_valid = 0;
        check("tgt_fetch", {valid_out, PCmas4_Out, fields()}, {1'b1, 32'h104, 64'd0, 32'h2000_0000});

        // flush together with stall, then flush together with a completion
        flush = 1; stall = 1;
        tick();
        flush = 0; stall = 0;
        check("flush_stall", valid_out, 0);
        bus.imem_valid = 1; bus.imem_rdata = 32'h3000_0000; flush = 1;
        tick();
        bus.imem_valid = 0; flush = 0;
        check("flush_drop", {valid_out, opcode}, {1'b0, 4'h2});
        check("flush_pc_adv", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h108});

        // Misaligned redirect
        br_taken = 1; br_target = 32'h102;
        tick();
        br_taken = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        check("fault_set", {fault, bus.imem_req, valid_out}, {1'b1, 1'b0, 1'b0});
        tick();
        check("fault_sticky", {fault, bus.imem_req}, {1'b1, 1'b0});
`else
        check("mis_wait", bus.imem_req, 0);
        bus.imem_valid = 1; bus.imem_rdata = 32'h4000_0000;
        tick();
        bus.imem_valid = 0;
        check("mis_aligned_req", {bus.imem_req, bus.imem_addr, valid_out}, {1'b1, 32'h100, 1'b0});
`endif

        // Reset mid-WAIT with a late beat arriving in BOOT
        tick();
        rst_n = 0;
        #1;
        check("midreset_outs", {bus.imem_req, bus.imem_addr, valid_out, PCmas4_Out}, 0);
        tick();
        rst_n = 1; bus.imem_valid = 1; bus.imem_rdata = 32'h5555_5555;
        tick();
        bus.imem_valid = 0;
        check("late_beat_ignored", {valid_out, fields(), PCmas4_Out}, 0);
        check("restart_req", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0});
`ifdef FETCH_ALIGN_CHECK_EN
        check("fault_cleared", fault, 0);
`endif

        // Randomized run against the program-flow scoreboard
        exp_next = 32'h0; br_flag = 0; pend = 0; cd = 0; n_req = 0; n_del = 0;
        out_addr = '0; br_tgt = '0;
        for (int k = 0; k < 600; k++) begin
            bus.imem_valid = 0;
            bus.imem_rdata = $urandom;
            if (bus.imem_req) begin
                e_addr = br_flag ? br_tgt : exp_next;
                check("rnd_req_addr", bus.imem_addr, e_addr);
                out_addr = e_addr;
                exp_next = e_addr + 32'd4;
                br_flag  = 0;
                pend     = 1;
                cd       = int'($urandom_range(1, 3));
                n_req++;
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    bus.imem_valid = 1;
                    bus.imem_rdata = mem_word(out_addr);
                    pend = 0;
                end
            end
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            br_taken = ($urandom_range(0, 15) == 0);
            tgt      = 32'($urandom_range(0, 4095));
`ifdef FETCH_ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            br_target = tgt;
            if (br_taken) begin
                br_flag = 1;
                br_tgt  = tgt & ~32'h3;
            end
            begin
                logic [95:0] prev;
                prev = snap();
                tick();
                if (flush) begin
                    check("rnd_flush", valid_out, 0);
                end else if (stall) begin
                    check("rnd_stall_hold", snap(), prev);
                end else if (valid_out) begin
                    n_del++;
                    check("rnd_wrong_path", {95'd0, br_flag}, 0);
                    check("rnd_fields", fields(), {64'd0, mem_word(out_addr)});
                    check("rnd_imm24", imm24, mem_word(out_addr) & 32'h00FF_FFFF);
                    check("rnd_pc4", PCmas4_Out, out_addr + 32'd4);
                end
            end
        end
        stall = 0; flush = 0; br_taken = 0; bus.imem_valid = 0;
        check("rnd_deliveries", {95'd0, n_del >= 20}, 1);
        check("rnd_requests", {95'd0, n_req >= 40}, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
